// File: rtl/vga_pkg.sv
// Shared timing constants and coordinate type for the VGA raster path.
// Both the timing generator and the downstream renderers import this package.
package vga_pkg;

  localparam int unsigned COORD_W   = 10;
  typedef logic [COORD_W-1:0] vga_coord_t;

  // 640x480 @ 60 Hz default raster
  localparam int unsigned H_VISIBLE = 640;
  localparam int unsigned H_FRONT   = 16;
  localparam int unsigned H_SYNC    = 96;
  localparam int unsigned H_BACK    = 48;
  localparam int unsigned V_VISIBLE = 480;
  localparam int unsigned V_FRONT   = 10;
  localparam int unsigned V_SYNC    = 2;
  localparam int unsigned V_BACK    = 33;

  localparam int unsigned H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  // Largest total a COORD_W-bit counter can represent
  localparam int unsigned COORD_SPAN = 1 << COORD_W;

endpackage

// File: rtl/vga_if.sv
// Raster output bundle: coordinates, sync pins, visible flag, frame markers.
// master = timing generator, slave = renderers / connector.
interface vga_if;
  import vga_pkg::*;

  vga_coord_t  DrawX;
  vga_coord_t  DrawY;
  logic        hs;
  logic        vs;
  logic        blank;
  logic        frame_start;
  logic [15:0] frame_count;

  modport master (output DrawX, DrawY, hs, vs, blank, frame_start, frame_count);
  modport slave  (input  DrawX, DrawY, hs, vs, blank, frame_start, frame_count);

endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis counter: counts 0..TERMINAL when enabled, wraps to 0 and
// flags a carry on the wrapping cycle. o_next exposes the value the counter
// will hold after the coming edge so the top can register decodes in step.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int unsigned TERMINAL = 799
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_en,
  output vga_coord_t o_count,
  output vga_coord_t o_next,
  output logic       o_carry
);

  localparam vga_coord_t TERM = vga_coord_t'(TERMINAL);

  vga_coord_t r_count;
  logic       w_at_term;

  assign w_at_term = (r_count == TERM);
  assign o_carry   = i_en && w_at_term;
  assign o_count   = r_count;

  // Next-value mux: hold, wrap, or increment
  always_comb begin
    o_next = r_count;
    if (i_en) o_next = w_at_term ? '0 : r_count + vga_coord_t'(1);
  end

  // Counter register, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_count <= '0;
    else     r_count <= o_next;
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Free-running VGA raster timing source. Sync/blank/frame_start are decoded
// from the counters' next values and registered, so every output switches on
// the same edge as DrawX/DrawY and describes the same pixel.
// Optional feature: define VGA_TIMING_FRAME_CNT_EN to build the 16-bit
// completed-frame counter; otherwise frame_count is tied to zero.
module vga_timing_gen #(
  parameter int unsigned H_VISIBLE = vga_pkg::H_VISIBLE,
  parameter int unsigned H_FRONT   = vga_pkg::H_FRONT,
  parameter int unsigned H_SYNC    = vga_pkg::H_SYNC,
  parameter int unsigned H_BACK    = vga_pkg::H_BACK,
  parameter int unsigned V_VISIBLE = vga_pkg::V_VISIBLE,
  parameter int unsigned V_FRONT   = vga_pkg::V_FRONT,
  parameter int unsigned V_SYNC    = vga_pkg::V_SYNC,
  parameter int unsigned V_BACK    = vga_pkg::V_BACK
) (
  input  logic  vga_clk,
  input  logic  reset,
  vga_if.master vga
);
  import vga_pkg::*;

  localparam int unsigned HT = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned VT = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  // Totals must fit the 10-bit counters
  if (HT > COORD_SPAN || VT > COORD_SPAN) begin : g_bad_totals
    $error("vga_timing_gen: H/V totals exceed 10-bit counter range");
  end

  localparam vga_coord_t HS_BEG = vga_coord_t'(H_VISIBLE + H_FRONT);
  localparam vga_coord_t HS_END = vga_coord_t'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam vga_coord_t VS_BEG = vga_coord_t'(V_VISIBLE + V_FRONT);
  localparam vga_coord_t VS_END = vga_coord_t'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam vga_coord_t H_VIS  = vga_coord_t'(H_VISIBLE);
  localparam vga_coord_t V_VIS  = vga_coord_t'(V_VISIBLE);

  vga_coord_t w_hc, w_vc, w_hc_nxt, w_vc_nxt;
  logic       w_h_carry, w_v_carry;
  logic       w_hs_nxt, w_vs_nxt, w_blank_nxt;
  logic       r_hs, r_vs, r_blank, r_frame_start;

  vga_axis_counter #(.TERMINAL(HT - 1)) u_hcnt (
    .clk     (vga_clk),
    .rst     (reset),
    .i_en    (1'b1),
    .o_count (w_hc),
    .o_next  (w_hc_nxt),
    .o_carry (w_h_carry)
  );

  vga_axis_counter #(.TERMINAL(VT - 1)) u_vcnt (
    .clk     (vga_clk),
    .rst     (reset),
    .i_en    (w_h_carry),
    .o_count (w_vc),
    .o_next  (w_vc_nxt),
    .o_carry (w_v_carry)
  );

  assign w_hs_nxt    = !((w_hc_nxt >= HS_BEG) && (w_hc_nxt < HS_END));
  assign w_vs_nxt    = !((w_vc_nxt >= VS_BEG) && (w_vc_nxt < VS_END));
  assign w_blank_nxt = (w_hc_nxt < H_VIS) && (w_vc_nxt < V_VIS);

  // Registered decode of the upcoming pixel; the vertical carry marks the
  // edge that lands on (0,0), which is exactly when frame_start must rise
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      r_hs          <= 1'b1;
      r_vs          <= 1'b1;
      r_blank       <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_hs          <= w_hs_nxt;
      r_vs          <= w_vs_nxt;
      r_blank       <= w_blank_nxt;
      r_frame_start <= w_v_carry;
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] r_frame_count;

  // Completed-frame counter, bumps on the same edge frame_start rises
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset)          r_frame_count <= '0;
    else if (w_v_carry) r_frame_count <= r_frame_count + 16'd1;
  end

  assign vga.frame_count = r_frame_count;
`else
  assign vga.frame_count = 16'h0000;
`endif

  assign vga.DrawX       = w_hc;
  assign vga.DrawY       = w_vc;
  assign vga.hs          = r_hs;
  assign vga.vs          = r_vs;
  assign vga.blank       = r_blank;
  assign vga.frame_start = r_frame_start;

endmodule
